instr_encoder: RTL and testbench

Sequential MIPS instruction encoder and program loader. Accepts decoded instruction fields (op, rs, rt, rd, shamt, funct, imm, addr) one beat at a time over a valid/ready handshake and packs each beat into a 32-bit R-, I- or J-format word. It writes the words into consecutive instruction-memory locations. It sits between the testbench or boot loader and the single-cycle core's instruction memory, and is the inverse of the core's field decoder.

---
 rtl/instr_encoder.sv | 119 +++++++++++
 tb/tb_instr_encoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - MIPS field-to-word encoder that loads consecutive instruction-memory words
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       addr,
    input  logic              last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       word;
    logic              accept;

    assign in_ready = (state == LOAD) && (count < CAPACITY);
    assign accept   = in_valid && in_ready;

    always_comb begin
        word = 32'd0;
        case (fmt)
            2'd0:    word = {op, rs, rt, rd, shamt, funct};
            2'd1:    word = {op, rs, rt, imm};
            default: word = {op, addr};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= BASE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 2'b00;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        ptr   <= BASE;
                        count <= '0;
                        err   <= 2'b00;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (fmt == 2'd3) begin
                            err[0] <= 1'b1;
                            if (last) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= ptr;
                            mem_wdata <= word;
                            ptr       <= ptr + 1'b1;
                            count     <= count + 1'b1;
                            // Filling the last free slot without last ends the session as an overflow.
                            if (last || (count == CAPACITY - 1'b1)) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                if (!last) err[1] <= 1'b1;
                            end
                        end
                    end else if (!in_ready) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        err[1] <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed vector bench for instr_encoder
module tb_instr_encoder;

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] addr;
        logic        last;
        logic [31:0] exp;
    } beat_t;

    logic clk = 1'b0;
    logic rst, start, in_valid, last;
    logic [1:0]  fmt;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] addr;

    logic        a_in_ready, a_mem_we, a_busy, a_done;
    logic [7:0]  a_mem_addr;
    logic [31:0] a_mem_wdata;
    logic [8:0]  a_count;
    logic [1:0]  a_err;

    logic        b_in_ready, b_mem_we, b_busy, b_done;
    logic [1:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [2:0]  b_count;
    logic [1:0]  b_err;

    int tests = 0;
    int fails = 0;
    beat_t vec [8];
    logic [7:0]  la [$];
    logic [31:0] ld [$];
    logic [1:0]  lb [$];

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
        .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .addr(addr), .last(last), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .count(a_count), .busy(a_busy), .done(a_done), .err(a_err)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
        .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .addr(addr), .last(last), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .count(b_count), .busy(b_busy), .done(b_done), .err(b_err)
    );

    always @(negedge clk) begin
        if (a_mem_we) begin
            la.push_back(a_mem_addr);
            ld.push_back(a_mem_wdata);
        end
        if (b_mem_we) lb.push_back(b_mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input beat_t b);
        fmt = b.fmt; op = b.op; rs = b.rs; rt = b.rt; rd = b.rd; shamt = b.shamt;
        funct = b.funct; imm = b.imm; addr = b.addr; last = b.last;
        in_valid = 1'b1;
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic clear_logs;
        la.delete(); ld.delete(); lb.delete();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".in_ready"}, 32'(a_in_ready), 32'd0);
        chk({tag, ".mem_we"}, 32'(a_mem_we), 32'd0);
        chk({tag, ".mem_addr"}, 32'(a_mem_addr), 32'd0);
        chk({tag, ".mem_wdata"}, a_mem_wdata, 32'd0);
        chk({tag, ".count"}, 32'(a_count), 32'd0);
        chk({tag, ".busy_done"}, {30'd0, a_busy, a_done}, 32'd0);
        chk({tag, ".err"}, 32'(a_err), 32'd0);
    endtask

    // One back-to-back session over vec[first +: n], then the write log is checked in order.
    task automatic run_session(input string tag, input int first, input int n,
                               input logic [1:0] exp_err);
        int j;
        clear_logs();
        pulse_start();
        for (int i = first; i < first + n; i++) begin
            drive(vec[i]);
            @(negedge clk);
        end
        chk({tag, ".end_we"}, 32'(a_mem_we), 32'd1);
        chk({tag, ".end_done"}, {30'd0, a_busy, a_done}, 32'd1);
        chk({tag, ".end_ready"}, 32'(a_in_ready), 32'd0);
        in_valid = 1'b0;
        last = 1'b0;
        repeat (2) @(negedge clk);
        j = 0;
        for (int i = first; i < first + n; i++) begin
            if (vec[i].fmt != 2'd3) begin
                if (j < la.size()) begin
                    chk($sformatf("%s.addr%0d", tag, j), 32'(la[j]), 32'(j));
                    chk($sformatf("%s.data%0d", tag, j), ld[j], vec[i].exp);
                end
                j++;
            end
        end
        chk({tag, ".nwrites"}, 32'(la.size()), 32'(j));
        chk({tag, ".count"}, 32'(a_count), 32'(j));
        chk({tag, ".err"}, 32'(a_err), 32'(exp_err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            fmt   op     rs     rt     rd     sh     funct  imm       addr          last  exp
        vec[0] = '{2'd0, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h0000, 26'h0000000, 1'b1, 32'h00221820};
        vec[1] = '{2'd1, 6'h08, 5'd0,  5'd8,  5'd31, 5'd31, 6'h3f, 16'h0005, 26'h3ffffff, 1'b0, 32'h20080005};
        vec[2] = '{2'd2, 6'h02, 5'd5,  5'd7,  5'd9,  5'd1,  6'h11, 16'hffff, 26'h0100000, 1'b1, 32'h08100000};
        vec[3] = '{2'd0, 6'h00, 5'd0,  5'd9,  5'd10, 5'd4,  6'h00, 16'h1234, 26'h0000000, 1'b0, 32'h00095100};
        vec[4] = '{2'd3, 6'h3f, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3f, 16'hffff, 26'h3ffffff, 1'b0, 32'h00000000};
        vec[5] = '{2'd0, 6'h00, 5'd4,  5'd5,  5'd6,  5'd0,  6'h22, 16'h0000, 26'h0000000, 1'b1, 32'h00853022};
        vec[6] = '{2'd1, 6'h23, 5'd29, 5'd8,  5'd0,  5'd0,  6'h00, 16'hfffc, 26'h0000000, 1'b0, 32'h8fa8fffc};
        vec[7] = '{2'd2, 6'h03, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h3ffffff, 1'b1, 32'h0fffffff};

        rst = 1'b0; start = 1'b0; in_valid = 1'b0; last = 1'b0;
        fmt = 2'd0; op = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0; imm = '0; addr = '0;
        #1 rst = 1'b1;
        #2 check_reset("rst0");
        @(negedge clk); rst = 1'b0;

        run_session("r_enc", 0, 1, 2'b00);
        run_session("ij", 1, 2, 2'b00);
        chk("ij.b_nwrites", 32'(lb.size()), 32'd2);
        if (lb.size() == 2) begin
            chk("ij.b_addr0", 32'(lb[0]), 32'd2);
            chk("ij.b_addr1", 32'(lb[1]), 32'd3);
        end
        run_session("rsv", 3, 3, 2'b01);

        // Restart from DONE, stall gap, and a start pulse inside LOAD.
        clear_logs();
        pulse_start();
        chk("rst_start.count", 32'(a_count), 32'd0);
        chk("rst_start.err", 32'(a_err), 32'd0);
        chk("rst_start.ready_busy", {30'd0, a_in_ready, a_busy}, 32'd3);
        drive(vec[6]);
        @(negedge clk);
        chk("stall.we1", 32'(a_mem_we), 32'd1);
        chk("stall.addr1", 32'(a_mem_addr), 32'd0);
        chk("stall.data1", a_mem_wdata, vec[6].exp);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("stall.gap_we", 32'(a_mem_we), 32'd0);
        chk("stall.gap_busy", 32'(a_busy), 32'd1);
        start = 1'b0;
        drive(vec[7]);
        @(negedge clk);
        chk("stall.we2", 32'(a_mem_we), 32'd1);
        chk("stall.addr2", 32'(a_mem_addr), 32'd1);
        chk("stall.data2", a_mem_wdata, vec[7].exp);
        chk("stall.count", 32'(a_count), 32'd2);
        chk("stall.done", 32'(a_done), 32'd1);
        in_valid = 1'b0; last = 1'b0;
        @(negedge clk);

        // Overflow on the 4-word instance, base 2.
        clear_logs();
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            drive(vec[3]);
            @(negedge clk);
            if (k == 3) begin
                chk("ovf.ready_after4", 32'(b_in_ready), 32'd0);
                chk("ovf.done_after4", 32'(b_done), 32'd1);
                chk("ovf.err_after4", 32'(b_err), 32'd2);
            end
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("ovf.nwrites", 32'(lb.size()), 32'd4);
        if (lb.size() == 4) begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("ovf.addr%0d", k), 32'(lb[k]), 32'((k + 2) % 4));
        end
        chk("ovf.count", 32'(b_count), 32'd4);
        chk("ovf.err", 32'(b_err), 32'd2);
        chk("ovf.done", 32'(b_done), 32'd1);

        // Mid-session asynchronous reset right after an accepting edge.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_reset("rst1");
        clear_logs();
        pulse_start();
        drive(vec[3]);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset("arst");
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst.nwrites", 32'(la.size()), 32'd0);
        chk("arst.idle_busy", 32'(a_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
